// File: rtl/obstacle_logic.sv
// Game-control FSM and collision checker for the flappy-bird datapath.
// Samples the in-scope pipe and bird position on each frame tick, then judges the hit on the following cycle.
module obstacle_logic #(
    parameter int SCREEN_W     = 640,
    parameter int BIRD_X       = 280,
    parameter int BIRD_W       = 16,
    parameter int BIRD_H       = 16,
    parameter int PIPE_W       = 80,
    parameter int GAP_H        = 120,
    parameter int FLOOR_Y      = 440,
    parameter int DEATH_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       flap,
    input  logic [9:0] pipe_x,
    input  logic [9:0] gap_y,
    input  logic [9:0] bird_y,
    output logic       count_EN,
    output logic       Lose,
    output logic       game_rst,
    output logic [1:0] game_state
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_PLAY  = 2'b01;
    localparam logic [1:0] S_DYING = 2'b10;
    localparam logic [1:0] S_OVER  = 2'b11;

    localparam int CW = $clog2(DEATH_FRAMES + 1);

    localparam logic [10:0] L_SCREEN_W   = 11'(SCREEN_W);
    localparam logic [10:0] L_BIRD_X     = 11'(BIRD_X);
    localparam logic [10:0] L_BIRD_RIGHT = 11'(BIRD_X + BIRD_W - 1);
    localparam logic [10:0] L_PIPE_SPAN  = 11'(PIPE_W - 1);
    localparam logic [10:0] L_BIRD_H     = 11'(BIRD_H);
    localparam logic [10:0] L_GAP_H      = 11'(GAP_H);
    localparam logic [10:0] L_FLOOR_Y    = 11'(FLOOR_Y);
    localparam logic [CW-1:0] L_DEATH    = CW'(DEATH_FRAMES);

    logic [1:0]    state_q, state_d;
    logic          flap_q;
    logic          count_en_q, count_en_d;
    logic          lose_q, lose_d;
    logic          game_rst_q, game_rst_d;
    logic          eval_q, eval_d;
    logic [CW-1:0] death_q, death_d;
    logic [9:0]    pipe_x_q, gap_y_q, bird_y_q;
    logic          capture;
    logic          flap_rise;
    logic          xov;
    logic          hit;
    logic [10:0]   pxW, gyW, byW;

    assign flap_rise = flap & ~flap_q;

    // All geometry is widened to 11 bits so pipe_x + PIPE_W - 1 and bird_y + BIRD_H never wrap.
    assign pxW = {1'b0, pipe_x_q};
    assign gyW = {1'b0, gap_y_q};
    assign byW = {1'b0, bird_y_q};

    assign xov = (pxW < L_SCREEN_W) && (pxW <= L_BIRD_RIGHT) && ((pxW + L_PIPE_SPAN) >= L_BIRD_X);
    assign hit = (xov && ((byW < gyW) || ((byW + L_BIRD_H) > (gyW + L_GAP_H))))
               || ((byW + L_BIRD_H) > L_FLOOR_Y);

    always_comb begin
        state_d    = state_q;
        count_en_d = 1'b0;
        lose_d     = lose_q;
        game_rst_d = 1'b0;
        eval_d     = 1'b0;
        death_d    = death_q;
        capture    = 1'b0;
        case (state_q)
            S_IDLE: begin
                lose_d = 1'b0;
                if (flap_rise) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                lose_d = 1'b0;
                if (eval_q && hit) begin
                    state_d = S_DYING;
                    lose_d  = 1'b1;
                    death_d = '0;
                end else if (frame_tick) begin
                    capture    = 1'b1;
                    count_en_d = 1'b1;
                    eval_d     = 1'b1;
                end
            end
            S_DYING: begin
                lose_d = 1'b1;
                if (frame_tick) begin
                    death_d = death_q + CW'(1);
                    if ((death_q + CW'(1)) == L_DEATH) begin
                        state_d = S_OVER;
                    end
                end
            end
            S_OVER: begin
                lose_d = 1'b1;
                if (flap_rise) begin
                    state_d    = S_IDLE;
                    lose_d     = 1'b0;
                    game_rst_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                lose_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            flap_q     <= 1'b0;
            count_en_q <= 1'b0;
            lose_q     <= 1'b0;
            game_rst_q <= 1'b1;
            eval_q     <= 1'b0;
            death_q    <= '0;
            pipe_x_q   <= '0;
            gap_y_q    <= '0;
            bird_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            flap_q     <= flap;
            count_en_q <= count_en_d;
            lose_q     <= lose_d;
            game_rst_q <= game_rst_d;
            eval_q     <= eval_d;
            death_q    <= death_d;
            if (capture) begin
                pipe_x_q <= pipe_x;
                gap_y_q  <= gap_y;
                bird_y_q <= bird_y;
            end
        end
    end

    assign count_EN   = count_en_q;
    assign Lose       = lose_q;
    assign game_rst   = game_rst_q;
    assign game_state = state_q;

endmodule
